// File: rtl/stream_upsizer.sv
// Packs narrow input beats into RATIO-lane words with a per-lane keep mask.
// The packing register doubles as the output register; a word leaves on r_valid && r_ready.
module stream_upsizer #(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [IN_WIDTH-1:0]       w_data,
  input  logic                      w_last,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [IN_WIDTH*RATIO-1:0] r_data,
  output logic [RATIO-1:0]          r_keep,
  output logic                      r_last
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  generate
    if (RATIO < 1) begin : g_ratio_check
      $fatal(1, "stream_upsizer: RATIO must be >= 1");
    end
  endgenerate

  logic [IDX_W-1:0]          idx;
  logic                      accept;
  logic                      fire;
  logic                      complete;
  int                        lane;
  logic [IN_WIDTH*RATIO-1:0] word_next;
  logic [RATIO-1:0]          keep_next;

  assign w_ready  = !r_valid || r_ready;
  assign accept   = w_valid && w_ready;
  assign fire     = r_valid && r_ready;
  assign complete = w_last || (idx == IDX_W'(RATIO - 1));
  assign lane     = (RATIO > 1) ? int'(idx) : 0;

  // A beat accepted while a word is leaving starts a fresh word, so no lanes carry over.
  always_comb begin
    word_next = r_valid ? '0 : r_data;
    keep_next = r_valid ? '0 : r_keep;
    word_next[lane*IN_WIDTH +: IN_WIDTH] = w_data;
    keep_next[lane] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      idx     <= '0;
    end else if (accept) begin
      r_data <= word_next;
      r_keep <= keep_next;
      if (complete) begin
        r_valid <= 1'b1;
        r_last  <= w_last;
        idx     <= '0;
      end else begin
        r_valid <= 1'b0;
        r_last  <= 1'b0;
        idx     <= idx + IDX_W'(1);
      end
    end else if (fire) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer: vector table for RATIO=4 plus stall, streaming,
// reset and RATIO=1 sequences.
module tb_stream_upsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_valid, w_ready, w_last, r_valid, r_ready, r_last;
  logic [7:0]  w_data;
  logic [31:0] r_data;
  logic [3:0]  r_keep;

  logic        u1_w_valid, u1_w_ready, u1_w_last, u1_r_valid, u1_r_ready, u1_r_last;
  logic [7:0]  u1_w_data, u1_r_data;
  logic [0:0]  u1_r_keep;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_upsizer #(.IN_WIDTH(8), .RATIO(4)) dut (
    .clk(clk), .rst(rst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_keep(r_keep), .r_last(r_last)
  );

  stream_upsizer #(.IN_WIDTH(8), .RATIO(1)) dut1 (
    .clk(clk), .rst(rst),
    .w_valid(u1_w_valid), .w_ready(u1_w_ready), .w_data(u1_w_data), .w_last(u1_w_last),
    .r_valid(u1_r_valid), .r_ready(u1_r_ready), .r_data(u1_r_data), .r_keep(u1_r_keep),
    .r_last(u1_r_last)
  );

  typedef struct {
    logic        wv;
    logic [7:0]  wd;
    logic        wl;
    logic        rr;
    logic        exp_wr;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic v, input logic [7:0] d, input logic l, input logic rr);
    w_valid = v; w_data = d; w_last = l; r_ready = rr;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   nwords;
    int   deasserts;
    logic [31:0] words[2];
    int   word_at[2];

    vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0011, 4'b0001, 1'b0};
    vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2211, 4'b0011, 1'b0};
    vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0033_2211, 4'b0111, 1'b0};
    vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4433_2211, 4'b1111, 1'b0};
    vecs[4] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_00AA, 4'b0001, 1'b0};
    vecs[5] = '{1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_BBAA, 4'b0011, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 4'b0000, 1'b0};
    vecs[7] = '{1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_00CC, 4'b0001, 1'b1};
    vecs[8] = '{1'b1, 8'hDD, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_00DD, 4'b0001, 1'b0};

    rst = 1'b1;
    w_valid = 1'b0; w_data = '0; w_last = 1'b0; r_ready = 1'b0;
    u1_w_valid = 1'b0; u1_w_data = '0; u1_w_last = 1'b0; u1_r_ready = 1'b0;
    repeat (2) tick();
    check("rst_r_valid", {31'd0, r_valid}, 32'd0);
    check("rst_r_data", r_data, 32'd0);
    check("rst_r_keep", {28'd0, r_keep}, 32'd0);
    check("rst_r_last", {31'd0, r_last}, 32'd0);
    check("rst_w_ready", {31'd0, w_ready}, 32'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      w_valid = vecs[i].wv; w_data = vecs[i].wd; w_last = vecs[i].wl; r_ready = vecs[i].rr;
      #1;
      check($sformatf("vec%0d_w_ready", i), {31'd0, w_ready}, {31'd0, vecs[i].exp_wr});
      tick();
      check($sformatf("vec%0d_r_valid", i), {31'd0, r_valid}, {31'd0, vecs[i].ev});
      check($sformatf("vec%0d_r_data", i), r_data, vecs[i].ed);
      check($sformatf("vec%0d_r_keep", i), {28'd0, r_keep}, {28'd0, vecs[i].ek});
      check($sformatf("vec%0d_r_last", i), {31'd0, r_last}, {31'd0, vecs[i].el});
    end
    w_valid = 1'b0;

    // Backpressure: full word held for 3 cycles, then fire and accept together.
    do_reset();
    beat(1'b1, 8'h11, 1'b0, 1'b1);
    beat(1'b1, 8'h22, 1'b0, 1'b1);
    beat(1'b1, 8'h33, 1'b0, 1'b1);
    beat(1'b1, 8'h44, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      w_valid = 1'b1; w_data = 8'h55; w_last = 1'b0; r_ready = 1'b0;
      #1;
      check($sformatf("stall%0d_w_ready", c), {31'd0, w_ready}, 32'd0);
      tick();
      check($sformatf("stall%0d_r_valid", c), {31'd0, r_valid}, 32'd1);
      check($sformatf("stall%0d_r_data", c), r_data, 32'h4433_2211);
      check($sformatf("stall%0d_r_keep", c), {28'd0, r_keep}, 32'hF);
      check($sformatf("stall%0d_r_last", c), {31'd0, r_last}, 32'd0);
    end
    r_ready = 1'b1;
    #1;
    check("release_w_ready", {31'd0, w_ready}, 32'd1);
    tick();
    check("release_r_valid", {31'd0, r_valid}, 32'd0);
    check("release_r_data", r_data, 32'h0000_0055);
    check("release_r_keep", {28'd0, r_keep}, 32'h1);
    w_valid = 1'b0;

    // Back-to-back streaming of 8 beats.
    do_reset();
    nwords = 0; deasserts = 0;
    for (int b = 0; b < 8; b++) begin
      w_valid = 1'b1; w_data = 8'(b + 1); w_last = 1'b0; r_ready = 1'b1;
      #1;
      if (!w_ready) deasserts++;
      tick();
      if (r_valid) begin
        if (nwords < 2) begin
          words[nwords] = r_data;
          word_at[nwords] = b;
        end
        nwords++;
      end
    end
    w_valid = 1'b0;
    check("stream_nwords", nwords, 32'd2);
    check("stream_deasserts", deasserts, 32'd0);
    if (nwords >= 2) begin
      check("stream_word0", words[0], 32'h0403_0201);
      check("stream_word0_at", word_at[0], 32'd3);
      check("stream_word1", words[1], 32'h0807_0605);
      check("stream_word1_at", word_at[1], 32'd7);
    end

    // Reset in the middle of a partial word.
    beat(1'b0, 8'h00, 1'b0, 1'b1);
    beat(1'b1, 8'hE1, 1'b0, 1'b1);
    beat(1'b1, 8'hE2, 1'b0, 1'b1);
    w_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_r_data", r_data, 32'd0);
    check("midrst_r_keep", {28'd0, r_keep}, 32'd0);
    tick();
    rst = 1'b0;
    beat(1'b1, 8'hC1, 1'b1, 1'b1);
    w_valid = 1'b0;
    check("after_rst_r_valid", {31'd0, r_valid}, 32'd1);
    check("after_rst_r_data", r_data, 32'h0000_00C1);
    check("after_rst_r_keep", {28'd0, r_keep}, 32'h1);
    check("after_rst_r_last", {31'd0, r_last}, 32'd1);

    // RATIO=1 instance.
    u1_w_valid = 1'b1; u1_w_data = 8'h7E; u1_w_last = 1'b0; u1_r_ready = 1'b1;
    tick();
    check("r1_a_r_valid", {31'd0, u1_r_valid}, 32'd1);
    check("r1_a_r_data", {24'd0, u1_r_data}, 32'h7E);
    check("r1_a_r_keep", {31'd0, u1_r_keep}, 32'd1);
    check("r1_a_r_last", {31'd0, u1_r_last}, 32'd0);
    u1_w_data = 8'h7F; u1_w_last = 1'b1;
    #1;
    check("r1_b_w_ready", {31'd0, u1_w_ready}, 32'd1);
    tick();
    check("r1_b_r_valid", {31'd0, u1_r_valid}, 32'd1);
    check("r1_b_r_data", {24'd0, u1_r_data}, 32'h7F);
    check("r1_b_r_keep", {31'd0, u1_r_keep}, 32'd1);
    check("r1_b_r_last", {31'd0, u1_r_last}, 32'd1);
    u1_w_valid = 1'b0; u1_w_last = 1'b0;
    tick();
    check("r1_c_r_valid", {31'd0, u1_r_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
